// File: rtl/lcd_timing_gen.sv
// Raster timing for the 480x272 LCD: active-area coordinates and flags, the renderer
// enable, and panel hsync_n/vsync_n/de delayed to match the renderer. Optional frame_tick output: `define FRAME_TICK_EN.
module lcd_timing_gen #(
  parameter int H_ACTIVE = 480,
  parameter int H_FP     = 2,
  parameter int H_SYNC   = 41,
  parameter int H_BP     = 2,
  parameter int V_ACTIVE = 272,
  parameter int V_FP     = 2,
  parameter int V_SYNC   = 10,
  parameter int V_BP     = 2
) (
  input  logic       clk_lcd,
  input  logic       rst_n,
  output logic [9:0] hcount_reg,
  output logic [8:0] Vcount_reg,
  output logic       flagh,
  output logic       flagv,
  output logic       rgb_en,
  output logic       hsync_n,
  output logic       vsync_n,
  output logic       de
`ifdef FRAME_TICK_EN
  ,
  output logic       frame_tick
`endif
);

  localparam int H_TOT = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOT = V_SYNC + V_BP + V_ACTIVE + V_FP;

  if (H_TOT >= 1024 || V_TOT >= 1024 || H_ACTIVE > 1024 || V_ACTIVE > 512) begin : gParamCheck
    $error("lcd_timing_gen: timing parameters do not fit the counter/coordinate widths");
  end

  localparam logic [9:0] H_LAST      = 10'(H_TOT - 1);
  localparam logic [9:0] H_BP_START  = 10'(H_SYNC);
  localparam logic [9:0] H_ACT_START = 10'(H_SYNC + H_BP);
  localparam logic [9:0] H_FP_START  = 10'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [9:0] V_LAST      = 10'(V_TOT - 1);
  localparam logic [9:0] V_BP_START  = 10'(V_SYNC);
  localparam logic [9:0] V_ACT_START = 10'(V_SYNC + V_BP);
  localparam logic [9:0] V_FP_START  = 10'(V_SYNC + V_BP + V_ACTIVE);

  typedef enum logic [1:0] {HS_SYNC, HS_BP, HS_ACT, HS_FP} hstate_t;
  typedef enum logic [1:0] {VS_SYNC, VS_BP, VS_ACT, VS_FP} vstate_t;

  function automatic hstate_t hDecode(input logic [9:0] c);
    if (c < H_BP_START)       return HS_SYNC;
    else if (c < H_ACT_START) return HS_BP;
    else if (c < H_FP_START)  return HS_ACT;
    else                      return HS_FP;
  endfunction

  function automatic vstate_t vDecode(input logic [9:0] c);
    if (c < V_BP_START)       return VS_SYNC;
    else if (c < V_ACT_START) return VS_BP;
    else if (c < V_FP_START)  return VS_ACT;
    else                      return VS_FP;
  endfunction

  logic [9:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  hstate_t    hstate_q, hstate_d;
  vstate_t    vstate_q, vstate_d;

  logic [9:0] hcount_q, hcount_d;
  logic [8:0] vcount_q, vcount_d;
  logic       flagh_q, flagh_d, flagv_q, flagv_d;
  logic       hs1_q, hs1_d, vs1_q, vs1_d;
  logic       ftick_q, ftick_d;
  logic       rgb_en_q, rgb_en_d, hs2_q, hs2_d, vs2_q, vs2_d;
  logic       de_q, de_d, hsync_n_q, hsync_n_d, vsync_n_q, vsync_n_d;

  // The state register tracks the decode of the counter it sits beside, so each
  // stage-1 flag is a one-clock-late copy of the region the counters are in.
  always_comb begin
    h_cnt_d = (h_cnt_q == H_LAST) ? 10'd0 : h_cnt_q + 10'd1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      v_cnt_d = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
    end
    hstate_d = hDecode(h_cnt_d);
    vstate_d = vDecode(v_cnt_d);

    flagh_d  = (hstate_q == HS_ACT);
    flagv_d  = (vstate_q == VS_ACT);
    hcount_d = flagh_d ? h_cnt_q - H_ACT_START : 10'd0;
    vcount_d = flagv_d ? 9'(v_cnt_q - V_ACT_START) : 9'd0;
    hs1_d    = (hstate_q == HS_SYNC);
    vs1_d    = (vstate_q == VS_SYNC);
    ftick_d  = (h_cnt_q == 10'd0) && (v_cnt_q == V_FP_START);

    rgb_en_d  = flagh_q & flagv_q;
    hs2_d     = hs1_q;
    vs2_d     = vs1_q;

    de_d      = rgb_en_q;
    hsync_n_d = ~hs2_q;
    vsync_n_d = ~vs2_q;
  end

  always_ff @(posedge clk_lcd) begin
    if (!rst_n) begin
      h_cnt_q   <= 10'd0;
      v_cnt_q   <= 10'd0;
      hstate_q  <= HS_SYNC;
      vstate_q  <= VS_SYNC;
      hcount_q  <= 10'd0;
      vcount_q  <= 9'd0;
      flagh_q   <= 1'b0;
      flagv_q   <= 1'b0;
      hs1_q     <= 1'b0;
      vs1_q     <= 1'b0;
      ftick_q   <= 1'b0;
      rgb_en_q  <= 1'b0;
      hs2_q     <= 1'b0;
      vs2_q     <= 1'b0;
      de_q      <= 1'b0;
      hsync_n_q <= 1'b1;
      vsync_n_q <= 1'b1;
    end else begin
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      hstate_q  <= hstate_d;
      vstate_q  <= vstate_d;
      hcount_q  <= hcount_d;
      vcount_q  <= vcount_d;
      flagh_q   <= flagh_d;
      flagv_q   <= flagv_d;
      hs1_q     <= hs1_d;
      vs1_q     <= vs1_d;
      ftick_q   <= ftick_d;
      rgb_en_q  <= rgb_en_d;
      hs2_q     <= hs2_d;
      vs2_q     <= vs2_d;
      de_q      <= de_d;
      hsync_n_q <= hsync_n_d;
      vsync_n_q <= vsync_n_d;
    end
  end

  assign hcount_reg = hcount_q;
  assign Vcount_reg = vcount_q;
  assign flagh      = flagh_q;
  assign flagv      = flagv_q;
  assign rgb_en     = rgb_en_q;
  assign de         = de_q;
  assign hsync_n    = hsync_n_q;
  assign vsync_n    = vsync_n_q;

`ifdef FRAME_TICK_EN
  assign frame_tick = ftick_q;
`else
  logic unusedTick;
  assign unusedTick = ftick_q;
`endif

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Bench for lcd_timing_gen: default-size and shrunken instances checked every cycle
// against an arithmetic raster model, plus a table of fixed timing points.
module tb_lcd_timing_gen;

  logic clk_lcd = 1'b0;
  always #5 clk_lcd = ~clk_lcd;

  logic rst_n = 1'b0;

  logic [9:0] hcountA, hcountB;
  logic [8:0] vcountA, vcountB;
  logic flaghA, flagvA, rgbA, hsnA, vsnA, deA;
  logic flaghB, flagvB, rgbB, hsnB, vsnB, deB;
`ifdef FRAME_TICK_EN
  logic tickA, tickB;
`endif

  lcd_timing_gen dutA (
    .clk_lcd(clk_lcd), .rst_n(rst_n),
    .hcount_reg(hcountA), .Vcount_reg(vcountA),
    .flagh(flaghA), .flagv(flagvA), .rgb_en(rgbA),
    .hsync_n(hsnA), .vsync_n(vsnA), .de(deA)
`ifdef FRAME_TICK_EN
    , .frame_tick(tickA)
`endif
  );

  lcd_timing_gen #(
    .H_ACTIVE(6), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(2), .V_SYNC(2), .V_BP(1)
  ) dutB (
    .clk_lcd(clk_lcd), .rst_n(rst_n),
    .hcount_reg(hcountB), .Vcount_reg(vcountB),
    .flagh(flaghB), .flagv(flagvB), .rgb_en(rgbB),
    .hsync_n(hsnB), .vsync_n(vsnB), .de(deB)
`ifdef FRAME_TICK_EN
    , .frame_tick(tickB)
`endif
  );

  typedef struct packed {
    logic [9:0] hc;
    logic [8:0] vc;
    logic fh, fv, rgb, de, hsn, vsn, ft;
  } outs_t;

  typedef struct {
    int    t;
    string name;
    int    value;
  } vec_t;

  int t = 0;
  bit haveReset = 0;
  int errors = 0;
  int checks = 0;

  // Expected outputs t cycles after the last reset edge, from raster position arithmetic.
  function automatic outs_t modelOut(input int tc, input int hs, input int hb, input int ha,
                                     input int hf, input int vs, input int vb, input int va,
                                     input int vf);
    outs_t o;
    int hTot, vTot, x, y;
    hTot = hs + hb + ha + hf;
    vTot = vs + vb + va + vf;
    o = '0;
    o.hsn = 1'b1;
    o.vsn = 1'b1;
    if (tc >= 1) begin
      x = (tc - 1) % hTot;
      y = ((tc - 1) / hTot) % vTot;
      o.fh = (x >= hs + hb) && (x < hs + hb + ha);
      o.fv = (y >= vs + vb) && (y < vs + vb + va);
      o.hc = o.fh ? 10'(x - hs - hb) : 10'd0;
      o.vc = o.fv ? 9'(y - vs - vb) : 9'd0;
`ifdef FRAME_TICK_EN
      o.ft = (x == 0) && (y == vs + vb + va);
`endif
    end
    if (tc >= 2) begin
      x = (tc - 2) % hTot;
      y = ((tc - 2) / hTot) % vTot;
      o.rgb = (x >= hs + hb) && (x < hs + hb + ha) && (y >= vs + vb) && (y < vs + vb + va);
    end
    if (tc >= 3) begin
      x = (tc - 3) % hTot;
      y = ((tc - 3) / hTot) % vTot;
      o.de  = (x >= hs + hb) && (x < hs + hb + ha) && (y >= vs + vb) && (y < vs + vb + va);
      o.hsn = !(x < hs);
      o.vsn = !(y < vs);
    end
    return o;
  endfunction

  task automatic checkOutput();
    outs_t eA, aA, eB, aB;
    logic ftA, ftB;
`ifdef FRAME_TICK_EN
    ftA = tickA;
    ftB = tickB;
`else
    ftA = 1'b0;
    ftB = 1'b0;
`endif
    eA = modelOut(t, 41, 2, 480, 2, 10, 2, 272, 2);
    eB = modelOut(t, 3, 1, 6, 2, 2, 1, 4, 2);
    aA = '{hcountA, vcountA, flaghA, flagvA, rgbA, deA, hsnA, vsnA, ftA};
    aB = '{hcountB, vcountB, flaghB, flagvB, rgbB, deB, hsnB, vsnB, ftB};
    checks++;
    if (aA !== eA) begin
      errors++;
      $display("[TB] FAIL modelA t=%0d actual=%h required=%h", t, aA, eA);
    end
    checks++;
    if (aB !== eB) begin
      errors++;
      $display("[TB] FAIL modelB t=%0d actual=%h required=%h", t, aB, eB);
    end
  endtask

  task automatic applyStimulus(input logic r);
    rst_n = r;
    @(posedge clk_lcd);
    if (!r) begin
      t = 0;
      haveReset = 1;
    end else begin
      t = t + 1;
    end
    @(negedge clk_lcd);
    if (haveReset) checkOutput();
  endtask

  function automatic int pickSig(input string nm);
    case (nm)
      "hsync_n":    return int'(hsnA);
      "vsync_n":    return int'(vsnA);
      "flagh":      return int'(flaghA);
      "flagv":      return int'(flagvA);
      "hcount_reg": return int'(hcountA);
      "Vcount_reg": return int'(vcountA);
      "rgb_en":     return int'(rgbA);
      "de":         return int'(deA);
      default:      return -1;
    endcase
  endfunction

  task automatic compareSig(input string nm, input int req);
    int act;
    act = pickSig(nm);
    checks++;
    if (act != req) begin
      errors++;
      $display("[TB] FAIL %s t=%0d actual=%0d required=%0d", nm, t, act, req);
    end
  endtask

  vec_t vecs[$];

  initial begin
    vecs = '{
      '{0,    "hsync_n", 1},   '{0,    "de", 0},        '{2,    "hsync_n", 1},
      '{3,    "hsync_n", 0},   '{3,    "vsync_n", 0},   '{43,   "hsync_n", 0},
      '{43,   "flagh", 0},     '{44,   "hsync_n", 1},   '{44,   "flagh", 1},
      '{44,   "hcount_reg", 0},'{45,   "hcount_reg", 1},'{523,  "hcount_reg", 479},
      '{523,  "flagh", 1},     '{524,  "flagh", 0},     '{524,  "hcount_reg", 0},
      '{5252, "vsync_n", 0},   '{5253, "vsync_n", 1},   '{6300, "flagv", 0},
      '{6301, "flagv", 1},     '{6344, "Vcount_reg", 0},'{6344, "rgb_en", 0},
      '{6345, "rgb_en", 1},    '{6345, "de", 0},        '{6346, "de", 1},
      '{6825, "de", 1},        '{6826, "de", 0},        '{6869, "Vcount_reg", 1}
    };

    for (int i = 0; i < 3; i++) applyStimulus(1'b0);
    compareSig("hsync_n", 1);
    compareSig("flagh", 0);

    foreach (vecs[i]) begin
      while (t < vecs[i].t) applyStimulus(1'b1);
      compareSig(vecs[i].name, vecs[i].value);
    end

    // Single-clock reset in the middle of an active line.
    while (t < 7000) applyStimulus(1'b1);
    compareSig("flagh", 1);
    applyStimulus(1'b0);
    compareSig("hcount_reg", 0);
    compareSig("Vcount_reg", 0);
    compareSig("flagh", 0);
    compareSig("flagv", 0);
    compareSig("rgb_en", 0);
    compareSig("de", 0);
    compareSig("hsync_n", 1);
    compareSig("vsync_n", 1);
    while (t < 3) applyStimulus(1'b1);
    compareSig("hsync_n", 0);
    while (t < 44) applyStimulus(1'b1);
    compareSig("hsync_n", 1);
    compareSig("flagh", 1);
    compareSig("hcount_reg", 0);

    // Random reset pulses of 1-3 clocks; both instances checked every cycle.
    for (int i = 0; i < 20000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        int len;
        len = $urandom_range(1, 3);
        for (int k = 0; k < len; k++) applyStimulus(1'b0);
      end else begin
        applyStimulus(1'b1);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog t=%0d actual=running required=finished", t);
    $fatal(1, "[TB] timeout");
  end

endmodule
